// File: rtl/param_fifo.sv
// param_fifo: parametrised synchronous FIFO with registered read data,
// programmable almost-full/almost-empty thresholds, occupancy count and
// sticky overflow/underflow flags that are cleared explicitly.
module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clear_err
);

  localparam int AW = $clog2(DEPTH);

  // Thresholds sized to the count register so every compare is width-matched.
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_CNT    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_CNT    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  // Storage is deliberately not reset; the pointers and count alone decide
  // which entries are live, so stale words can never be popped.
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rdData;
  logic             r_rdValid;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wrAccept;
  logic w_rdAccept;
  logic w_ovfEvent;
  logic w_udfEvent;

  // Status decodes come from the registered count only, so a request never
  // sees its own effect in the same cycle (no bypass, no lookahead).
  always_comb begin
    w_full     = (r_count == DEPTH_CNT);
    w_empty    = (r_count == '0);
    w_wrAccept = wr_en && !w_full;
    w_rdAccept = rd_en && !w_empty;
    w_ovfEvent = wr_en && w_full;
    w_udfEvent = rd_en && w_empty;
  end

  // Array write; gated by reset so a write request coinciding with reset
  // leaves no trace.
  always_ff @(posedge clk) begin
    if (!reset && w_wrAccept) begin
      r_mem[r_wrPtr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally because
  // DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wrAccept) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_rdAccept) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      if (w_wrAccept && !w_rdAccept) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_rdAccept && !w_wrAccept) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  // Registered read port: rd_valid pulses for exactly one cycle per pop and
  // rd_data holds its last value otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= w_rdAccept;
      if (w_rdAccept) begin
        r_rdData <= r_mem[r_rdPtr];
      end
    end
  end

  // Sticky error flags; a new error event on the same edge beats clear_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovfEvent) begin
        r_overflow <= 1'b1;
      end else if (clear_err) begin
        r_overflow <= 1'b0;
      end
      if (w_udfEvent) begin
        r_underflow <= 1'b1;
      end else if (clear_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign rd_data      = r_rdData;
  assign rd_valid     = r_rdValid;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: drives two param_fifo configurations (8x32 default and
// 16x4 with tight thresholds) and compares every cycle against a queue-based
// behavioural model of the FIFO.
module tb_param_fifo;

  logic        clk;
  logic        reset;
  logic        wrEn;
  logic        rdEn;
  logic        clearErr;
  logic [15:0] wrData;

  logic [7:0]  rdDataA;
  logic        rdValidA, fullA, emptyA, afA, aeA, ovfA, udfA;
  logic [5:0]  countA;

  logic [15:0] rdDataB;
  logic        rdValidB, fullB, emptyB, afB, aeB, ovfB, udfB;
  logic [2:0]  countB;

  int checks   = 0;
  int failures = 0;

  // Model state: contents as a plain queue plus the few registered outputs.
  int          mq[$];
  int          mDepth, mAf, mAe, mMask;
  int          mRdData;
  bit          mRdValid, mOvf, mUdf;
  bit          sel;

  param_fifo dutA (
    .clk(clk), .reset(reset), .wr_en(wrEn), .wr_data(wrData[7:0]),
    .rd_en(rdEn), .rd_data(rdDataA), .rd_valid(rdValidA), .count(countA),
    .full(fullA), .empty(emptyA), .almost_full(afA), .almost_empty(aeA),
    .overflow(ovfA), .underflow(udfA), .clear_err(clearErr)
  );

  param_fifo #(.WIDTH(16), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dutB (
    .clk(clk), .reset(reset), .wr_en(wrEn), .wr_data(wrData),
    .rd_en(rdEn), .rd_data(rdDataB), .rd_valid(rdValidB), .count(countB),
    .full(fullB), .empty(emptyB), .almost_full(afB), .almost_empty(aeB),
    .overflow(ovfB), .underflow(udfB), .clear_err(clearErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s (dut=%s): got %0h expected %0h at %0t",
               tag, sel ? "B" : "A", observed, expected, $time);
    end
  endtask

  // Compare every output of the selected DUT against the model.
  task checkAll;
    int n;
    n = mq.size();
    checkOutput("count",        sel ? 32'(countB)   : 32'(countA),   32'(n));
    checkOutput("full",         sel ? 32'(fullB)    : 32'(fullA),    32'(n == mDepth));
    checkOutput("empty",        sel ? 32'(emptyB)   : 32'(emptyA),   32'(n == 0));
    checkOutput("almost_full",  sel ? 32'(afB)      : 32'(afA),      32'(n >= mAf));
    checkOutput("almost_empty", sel ? 32'(aeB)      : 32'(aeA),      32'(n <= mAe));
    checkOutput("overflow",     sel ? 32'(ovfB)     : 32'(ovfA),     32'(mOvf));
    checkOutput("underflow",    sel ? 32'(udfB)     : 32'(udfA),     32'(mUdf));
    checkOutput("rd_valid",     sel ? 32'(rdValidB) : 32'(rdValidA), 32'(mRdValid));
    checkOutput("rd_data",      sel ? 32'(rdDataB)  : 32'(rdDataA),  32'(mRdData));
  endtask

  // Apply one cycle of inputs, advance the model by the FIFO rules, then
  // check the DUT shortly after the edge.
  task applyStimulus(input bit rst, input bit wr, input int wdata, input bit rd, input bit clr);
    bit isFull, isEmpty, ovfEv, udfEv;
    @(negedge clk);
    reset    = rst;
    wrEn     = wr;
    wrData   = 16'(wdata);
    rdEn     = rd;
    clearErr = clr;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mRdData  = 0;
      mRdValid = 0;
      mOvf     = 0;
      mUdf     = 0;
    end else begin
      isFull  = (mq.size() == mDepth);
      isEmpty = (mq.size() == 0);
      ovfEv   = wr && isFull;
      udfEv   = rd && isEmpty;
      if (rd && !isEmpty) begin
        mRdData  = mq.pop_front();
        mRdValid = 1;
      end else begin
        mRdValid = 0;
      end
      if (wr && !isFull) mq.push_back(wdata & mMask);
      mOvf = ovfEv ? 1'b1 : (clr ? 1'b0 : mOvf);
      mUdf = udfEv ? 1'b1 : (clr ? 1'b0 : mUdf);
    end
    #1;
    checkAll();
  endtask

  // Random traffic with occasional clears and rare resets.
  task randomTraffic(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 55,
                    int'($urandom() & 32'hFFFF), $urandom_range(0, 99) < 50,
                    $urandom_range(0, 99) < 10);
    end
  endtask

  initial begin
    reset = 1'b0; wrEn = 1'b0; rdEn = 1'b0; clearErr = 1'b0; wrData = '0;

    // Configuration A: 8-bit x 32, AF=28, AE=4.
    sel = 0; mDepth = 32; mAf = 28; mAe = 4; mMask = 32'hFF;
    mRdData = 0; mRdValid = 0; mOvf = 0; mUdf = 0;
    applyStimulus(1, 0, 0, 0, 0);

    // Fill with 0x00..0x1F, then push 0xAA into a full FIFO and clear.
    for (int i = 0; i < 32; i++) applyStimulus(0, 1, i, 0, 0);
    applyStimulus(0, 1, 8'hAA, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) applyStimulus(0, 0, 0, 1, 0);

    // Underflow straight after reset; set must beat a same-edge clear.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Simultaneous on empty accepts only the write; then hold 16 words
    // through 100 cycles of concurrent traffic across several wraps.
    applyStimulus(0, 1, 8'h80, 1, 0);
    for (int i = 0; i < 15; i++) applyStimulus(0, 1, 8'h81 + i, 0, 0);
    for (int i = 0; i < 100; i++) applyStimulus(0, 1, i, 1, 0);

    // Reset in the middle of traffic with 10 words stored.
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 1, 8'h33, 1, 0);
    applyStimulus(0, 1, 8'h5A, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);

    randomTraffic(600);

    // Configuration B: 16-bit x 4, AF=3, AE=1.
    sel = 1; mDepth = 4; mAf = 3; mAe = 1; mMask = 32'hFFFF;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'hA000 + i * 16'h0101, 0, 0);
    applyStimulus(0, 1, 16'hBEEF, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 16'hC000 + i, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 16'h1234 + i * 16'h0111, 1, 0);
    randomTraffic(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
